// File: rtl/tcam_prio.sv
// Ternary CAM: per-entry care masks, lowest-index priority, 2-stage search.
// Optional TCAM_MULTI_MATCH_EN adds rsp_match_cnt / rsp_multi outputs.
module tcam_prio #(
  parameter int KEY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  ready,
  input  logic [1:0]            op,
  input  logic [KEY_WIDTH-1:0]  key,
  input  logic [KEY_WIDTH-1:0]  mask_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ack,
  output logic                  rsp_hit,
`ifdef TCAM_MULTI_MATCH_EN
  output logic [ADDR_WIDTH:0]   rsp_match_cnt,
  output logic                  rsp_multi,
`endif
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  logic [KEY_WIDTH-1:0]  key_q  [ENTRIES];
  logic [KEY_WIDTH-1:0]  key_d  [ENTRIES];
  logic [KEY_WIDTH-1:0]  mask_q [ENTRIES];
  logic [KEY_WIDTH-1:0]  mask_d [ENTRIES];
  logic [DATA_WIDTH-1:0] data_q [ENTRIES];
  logic [DATA_WIDTH-1:0] data_d [ENTRIES];

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [ENTRIES-1:0]    match_q, match_d;
  logic [ENTRIES-1:0]    hit_vec;
  logic                  s1_vld_q, s1_vld_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  accept;
  logic                  is_wr, is_srch, is_inv, is_fl;
  logic [ADDR_WIDTH-1:0] win;

  assign ready   = !s1_vld_q && !(rsp_valid_q && !rsp_ack);
  assign accept  = req && ready;
  assign is_wr   = (op == 2'b00);
  assign is_srch = (op == 2'b01);
  assign is_inv  = (op == 2'b10);
  assign is_fl   = (op == 2'b11);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = valid_q[i] &&
                   (((key ^ key_q[i]) & mask_q[i]) == '0);
    end
  end

  // Scan from the top so the lowest set index is left in win.
  always_comb begin
    win = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_q[i]) win = ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    key_d       = key_q;
    mask_d      = mask_q;
    data_d      = data_q;
    valid_d     = valid_q;
    match_d     = match_q;
    s1_vld_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      unique case (1'b1)
        is_wr: begin
          key_d[addr_in]   = key;
          mask_d[addr_in]  = mask_in;
          data_d[addr_in]  = data_in;
          valid_d[addr_in] = 1'b1;
        end
        is_srch: begin
          match_d  = hit_vec;
          s1_vld_d = 1'b1;
        end
        is_inv: valid_d[addr_in] = 1'b0;
        is_fl:  valid_d = '0;
      endcase
    end

    if (s1_vld_q) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = |match_q;
      rsp_addr_d  = (|match_q) ? win : '0;
      rsp_data_d  = (|match_q) ? data_q[win] : '0;
    end else if (rsp_valid_q && rsp_ack) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    key_q  <= key_d;
    mask_q <= mask_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      match_q     <= '0;
      s1_vld_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      match_q     <= match_d;
      s1_vld_q    <= s1_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;

`ifdef TCAM_MULTI_MATCH_EN
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                multi_q, multi_d;
  logic [ADDR_WIDTH:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      pop = pop + (ADDR_WIDTH+1)'(match_q[i]);
    end
    cnt_d   = cnt_q;
    multi_d = multi_q;
    if (s1_vld_q) begin
      cnt_d   = pop;
      multi_d = (pop > (ADDR_WIDTH+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      multi_q <= multi_d;
    end
  end

  assign rsp_match_cnt = cnt_q;
  assign rsp_multi     = multi_q;
`else
  // Match counting absent: no popcount state in this build.
`endif

endmodule
